// File: rtl/shreg_frame_decoder_if.sv
// rtl/shreg_frame_decoder_if.sv - serial input and decoded configuration bundle for shreg_frame_decoder
interface shreg_frame_decoder_if #(
   parameter int DATA_W = 32
);
   logic              ser_in;
   logic              ser_en;
   logic [DATA_W-1:0] cfg_data;
   logic              cfg_update;
   logic              parity_err;
   logic              timeout_err;
   logic              busy;
   logic [7:0]        frame_cnt;
   logic [7:0]        err_cnt;

   modport master (
      output ser_in, ser_en,
      input  cfg_data, cfg_update, parity_err, timeout_err, busy, frame_cnt, err_cnt
   );

   modport slave (
      input  ser_in, ser_en,
      output cfg_data, cfg_update, parity_err, timeout_err, busy, frame_cnt, err_cnt
   );
endinterface

// File: rtl/shreg_frame_decoder.sv
// rtl/shreg_frame_decoder.sv - sync-hunting serial frame decoder committing even-parity payloads to a config register
module shreg_frame_decoder #(
   parameter int                DATA_W    = 32,
   parameter logic [7:0]        SYNC      = 8'hA5,
   parameter int                IDLE_MAX  = 64,
   parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
   input logic                clk,
   input logic                rst,
   shreg_frame_decoder_if.slave bus
);
   localparam int BW = $clog2(DATA_W);
   localparam int IW = $clog2(IDLE_MAX + 1);

   typedef enum logic [1:0] {HUNT, PAYLOAD, PARITY} state_t;

   state_t            state_q, state_d;
   logic [7:0]        window;
   logic [DATA_W-1:0] payload;
   logic [BW-1:0]     bit_cnt;
   logic [IW-1:0]     idle_cnt;
   logic              acc;
   logic [DATA_W-1:0] cfg_data;
   logic              cfg_update, parity_err, timeout_err, busy;
   logic [7:0]        frame_cnt, err_cnt;

   logic [7:0] win_next;
   logic       idle_expired;
   logic       commit, perr_d, terr_d;

   assign win_next     = {window[6:0], bus.ser_in};
   assign idle_expired = (idle_cnt == IW'(IDLE_MAX - 1));

   always_comb begin
      state_d = state_q;
      commit  = 1'b0;
      perr_d  = 1'b0;
      terr_d  = 1'b0;
      case (state_q)
         HUNT: begin
            if (bus.ser_en && win_next == SYNC) state_d = PAYLOAD;
         end
         PAYLOAD: begin
            if (bus.ser_en) begin
               if (bit_cnt == BW'(DATA_W - 1)) state_d = PARITY;
            end else if (idle_expired) begin
               state_d = HUNT;
               terr_d  = 1'b1;
            end
         end
         PARITY: begin
            if (bus.ser_en) begin
               state_d = HUNT;
               commit  = ~(acc ^ bus.ser_in);
               perr_d  = acc ^ bus.ser_in;
            end else if (idle_expired) begin
               state_d = HUNT;
               terr_d  = 1'b1;
            end
         end
         default: state_d = HUNT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= HUNT;
         window      <= '0;
         payload     <= '0;
         bit_cnt     <= '0;
         idle_cnt    <= '0;
         acc         <= 1'b0;
         cfg_data    <= RESET_VAL;
         cfg_update  <= 1'b0;
         parity_err  <= 1'b0;
         timeout_err <= 1'b0;
         busy        <= 1'b0;
         frame_cnt   <= '0;
         err_cnt     <= '0;
      end else begin
         state_q     <= state_d;
         cfg_update  <= commit;
         parity_err  <= perr_d;
         timeout_err <= terr_d;
         busy        <= (state_d != HUNT);
         if (commit) begin
            cfg_data  <= payload;
            frame_cnt <= frame_cnt + 8'd1;
         end
         if ((perr_d || terr_d) && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;

         if (bus.ser_en) begin
            idle_cnt <= '0;
            case (state_q)
               HUNT: begin
                  // window is cleared on a match so the next hunt starts fresh
                  window  <= (state_d == PAYLOAD) ? 8'h00 : win_next;
                  bit_cnt <= '0;
                  acc     <= 1'b0;
               end
               PAYLOAD: begin
                  payload <= {payload[DATA_W-2:0], bus.ser_in};
                  acc     <= acc ^ bus.ser_in;
                  bit_cnt <= bit_cnt + BW'(1);
               end
               default: ;
            endcase
         end else if (state_q != HUNT) begin
            idle_cnt <= terr_d ? '0 : idle_cnt + IW'(1);
         end
      end
   end

   assign bus.cfg_data    = cfg_data;
   assign bus.cfg_update  = cfg_update;
   assign bus.parity_err  = parity_err;
   assign bus.timeout_err = timeout_err;
   assign bus.busy        = busy;
   assign bus.frame_cnt   = frame_cnt;
   assign bus.err_cnt     = err_cnt;
endmodule

// File: tb/tb_shreg_frame_decoder.sv
// tb/tb_shreg_frame_decoder.sv - randomized and directed bench for shreg_frame_decoder with a bit-queue reference model
module tb_shreg_frame_decoder;
   localparam int          DATA_W    = 32;
   localparam logic [7:0]  SYNC      = 8'hA5;
   localparam int          IDLE_MAX  = 64;
   localparam logic [31:0] RESET_VAL = 32'h0;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   shreg_frame_decoder_if #(.DATA_W(DATA_W)) bus ();

   shreg_frame_decoder #(
      .DATA_W(DATA_W), .SYNC(SYNC), .IDLE_MAX(IDLE_MAX), .RESET_VAL(RESET_VAL)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: phase 0 hunt, 1 collecting payload bits, 2 awaiting parity bit
   int          m_phase;
   logic [7:0]  m_win;
   bit          pay_q[$];
   int          m_idle;
   logic [31:0] m_cfg;
   logic        m_upd, m_perr, m_terr, m_busy;
   int          m_frames, m_errs;
   bit          m_valid = 1'b0;

   always @(posedge clk) begin
      m_upd  = 1'b0;
      m_perr = 1'b0;
      m_terr = 1'b0;
      if (rst) begin
         m_phase = 0; m_win = 8'h00; pay_q.delete(); m_idle = 0;
         m_cfg = RESET_VAL; m_frames = 0; m_errs = 0; m_valid = 1'b1;
      end else if (m_valid) begin
         if (bus.ser_en) begin
            m_idle = 0;
            if (m_phase == 0) begin
               m_win = {m_win[6:0], bus.ser_in};
               if (m_win == SYNC) begin
                  m_phase = 1; m_win = 8'h00; pay_q.delete();
               end
            end else if (m_phase == 1) begin
               pay_q.push_back(bus.ser_in);
               if (pay_q.size() == DATA_W) m_phase = 2;
            end else begin
               int          ones;
               logic [31:0] v;
               ones = int'(bus.ser_in);
               v    = 32'h0;
               foreach (pay_q[i]) begin
                  ones += int'(pay_q[i]);
                  v[DATA_W-1-i] = pay_q[i];
               end
               if (ones % 2 == 0) begin
                  m_cfg = v; m_upd = 1'b1; m_frames = (m_frames + 1) % 256;
               end else begin
                  m_perr = 1'b1;
                  if (m_errs < 255) m_errs++;
               end
               m_phase = 0;
            end
         end else if (m_phase != 0) begin
            m_idle++;
            if (m_idle == IDLE_MAX) begin
               m_terr = 1'b1;
               if (m_errs < 255) m_errs++;
               m_phase = 0; m_idle = 0;
            end
         end
      end
      m_busy = (m_phase != 0);
   end

   always @(negedge clk) begin
      if (m_valid) begin
         chk("cfg_data", 64'(bus.cfg_data), 64'(m_cfg));
         chk("cfg_update", 64'(bus.cfg_update), 64'(m_upd));
         chk("parity_err", 64'(bus.parity_err), 64'(m_perr));
         chk("timeout_err", 64'(bus.timeout_err), 64'(m_terr));
         chk("busy", 64'(bus.busy), 64'(m_busy));
         chk("frame_cnt", 64'(bus.frame_cnt), 64'(m_frames));
         chk("err_cnt", 64'(bus.err_cnt), 64'(m_errs));
      end
   end

   task automatic bit_tx(logic b);
      @(negedge clk);
      bus.ser_en = 1'b1;
      bus.ser_in = b;
   endtask

   task automatic idle(int n);
      repeat (n) begin
         @(negedge clk);
         bus.ser_en = 1'b0;
         bus.ser_in = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic sync_tx();
      for (int i = 7; i >= 0; i--) bit_tx(SYNC[i]);
   endtask

   task automatic frame(logic [31:0] p, bit bad, int gap_at, int gap_len);
      sync_tx();
      for (int i = DATA_W - 1; i >= 0; i--) begin
         if (DATA_W - 1 - i == gap_at) idle(gap_len);
         bit_tx(p[i]);
      end
      bit_tx((^p) ^ bad);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.ser_en = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic [31:0] p;
      logic [5:0]  noise;
      rst = 1'b0;
      bus.ser_en = 1'b0;
      bus.ser_in = 1'b0;
      do_reset();
      chk("rst_cfg", 64'(bus.cfg_data), 64'h0);
      chk("rst_busy", 64'(bus.busy), 64'h0);
      chk("rst_cnts", {48'h0, bus.frame_cnt, bus.err_cnt}, 64'h0);

      frame(32'hDEADBEEF, 1'b0, -1, 0);
      idle(1);
      chk("good_cfg", 64'(bus.cfg_data), 64'hDEADBEEF);
      chk("good_pulse", 64'(bus.cfg_update), 64'h1);
      chk("good_cnts", {48'h0, bus.frame_cnt, bus.err_cnt}, 64'h0100);

      frame(32'hDEADBEEF, 1'b1, -1, 0);
      idle(1);
      chk("bad_pulse", 64'(bus.parity_err), 64'h1);
      chk("bad_cfg", 64'(bus.cfg_data), 64'hDEADBEEF);
      chk("bad_cnts", {48'h0, bus.frame_cnt, bus.err_cnt}, 64'h0101);
      chk("bad_busy", 64'(bus.busy), 64'h0);

      noise = 6'b101001;
      for (int i = 5; i >= 0; i--) bit_tx(noise[i]);
      frame(32'hA5A5A5A5, 1'b0, -1, 0);
      idle(1);
      chk("noise_cfg", 64'(bus.cfg_data), 64'hA5A5A5A5);
      chk("noise_cnts", {48'h0, bus.frame_cnt, bus.err_cnt}, 64'h0201);

      frame(32'hCAFEF00D, 1'b0, 12, IDLE_MAX - 1);
      idle(1);
      chk("gap_ok_cfg", 64'(bus.cfg_data), 64'hCAFEF00D);
      chk("gap_ok_cnt", 64'(bus.frame_cnt), 64'h3);

      p = 32'h13579BDF;
      sync_tx();
      for (int i = 31; i >= 22; i--) bit_tx(p[i]);
      idle(IDLE_MAX);
      idle(1);
      chk("tmo_pulse", 64'(bus.timeout_err), 64'h1);
      chk("tmo_cnts", {48'h0, bus.frame_cnt, bus.err_cnt}, 64'h0302);
      chk("tmo_cfg", 64'(bus.cfg_data), 64'hCAFEF00D);
      chk("tmo_busy", 64'(bus.busy), 64'h0);

      sync_tx();
      for (int i = 31; i >= 22; i--) bit_tx(p[i]);
      do_reset();
      chk("mid_rst_cfg", 64'(bus.cfg_data), 64'h0);
      chk("mid_rst_busy", 64'(bus.busy), 64'h0);
      chk("mid_rst_cnts", {48'h0, bus.frame_cnt, bus.err_cnt}, 64'h0);
      frame(32'h12345678, 1'b0, -1, 0);
      idle(1);
      chk("post_rst_cfg", 64'(bus.cfg_data), 64'h12345678);
      chk("post_rst_cnts", {48'h0, bus.frame_cnt, bus.err_cnt}, 64'h0100);

      do_reset();
      repeat (256) frame($urandom, 1'b0, -1, 0);
      idle(1);
      chk("wrap_cnts", {48'h0, bus.frame_cnt, bus.err_cnt}, 64'h0000);
      repeat (300) frame($urandom, 1'b1, -1, 0);
      idle(1);
      chk("sat_cnts", {48'h0, bus.frame_cnt, bus.err_cnt}, 64'h00FF);

      do_reset();
      repeat (120) begin
         int n;
         n = $urandom_range(0, 6);
         repeat (n) bit_tx(1'($urandom_range(0, 1)));
         if ($urandom_range(0, 3) == 0)
            frame($urandom, ($urandom_range(0, 3) == 0), $urandom_range(0, 31),
                  $urandom_range(1, IDLE_MAX + 4));
         else
            frame($urandom, ($urandom_range(0, 3) == 0), -1, 0);
         if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 5));
      end
      idle(IDLE_MAX + 2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
